// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared definitions for the processor I/O port controller:
//               default sizes, a constant-safe clog2, the output port index
//               type and the flag vector types.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int DW_DEFAULT     = 33;  // sign + mantissa + exponent
    localparam int NUIOIN_DEFAULT = 4;
    localparam int NUIOOU_DEFAULT = 4;

    // Ceiling log2, never below 1 so that index vectors always have a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int IN_IDX_W  = clog2(NUIOIN_DEFAULT);
    localparam int OUT_IDX_W = clog2(NUIOOU_DEFAULT);

    typedef logic [OUT_IDX_W-1:0]      out_port_idx_t;
    typedef logic [NUIOIN_DEFAULT-1:0] underrun_vec_t;
    typedef logic [NUIOOU_DEFAULT-1:0] overrun_vec_t;

endpackage : io_pkg
`default_nettype wire

// File: rtl/io_port_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search. Grants the first requester
//               at or after the pointer, wrapping from N-1 back to 0.
// Ports       : req     - request vector
//               ptr     - index where the search starts (must be < N)
//               gnt     - one-hot grant
//               gnt_idx - index of the granted requester
//               gnt_any - at least one request was present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import io_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // One bit wider than the index so ptr+i can be wrapped without overflow.
    logic [IW:0] w_pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = {1'b0, ptr} + (IW+1)'(i);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!gnt_any && req[w_pos[IW-1:0]]) begin
                gnt[w_pos[IW-1:0]] = 1'b1;
                gnt_idx            = w_pos[IW-1:0];
                gnt_any            = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_port_ctrl
// Description : I/O scheduler between the processor port strobes and the
//               outside world. One holding slot per input port (filled by
//               producers via valid/ready, read by the processor with zero
//               latency) and one pending slot per output port, drained
//               round-robin into a single registered sink channel. Sticky
//               underrun/overrun flags report stale or lost data; the
//               processor side never stalls.
// Ports       : clk, rst (synchronous, active-low)
//               req_in/proc_rdata          - processor read strobe / data
//               out_en/proc_wdata          - processor write strobe / data
//               src_data/src_valid/src_ready - producer interface per port
//               snk_data/snk_port/snk_valid/snk_ready - shared sink channel
//               underrun/overrun/clr_flags - sticky status flags
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int NUIOIN = NUIOIN_DEFAULT,
    parameter int NUIOOU = NUIOOU_DEFAULT,
    parameter int DW     = DW_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUIOIN-1:0]         req_in,
    output logic [DW-1:0]             proc_rdata,
    input  logic [NUIOOU-1:0]         out_en,
    input  logic [DW-1:0]             proc_wdata,
    input  logic [NUIOIN*DW-1:0]      src_data,
    input  logic [NUIOIN-1:0]         src_valid,
    output logic [NUIOIN-1:0]         src_ready,
    output logic [DW-1:0]             snk_data,
    output logic [clog2(NUIOOU)-1:0]  snk_port,
    output logic                      snk_valid,
    input  logic                      snk_ready,
    output logic [NUIOIN-1:0]         underrun,
    output logic [NUIOOU-1:0]         overrun,
    input  logic                      clr_flags
);

    localparam int c_OIW = clog2(NUIOOU);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0]     r_slot_data [NUIOIN];
    logic [NUIOIN-1:0] r_full;
    logic [DW-1:0]     r_odata [NUIOOU];
    logic [NUIOOU-1:0] r_pend;
    logic [DW-1:0]     r_snk_data;
    logic [c_OIW-1:0]  r_snk_port;
    logic              r_snk_valid;
    logic [c_OIW-1:0]  r_ptr;
    logic [NUIOIN-1:0] r_underrun;
    logic [NUIOOU-1:0] r_overrun;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    logic [NUIOIN-1:0] w_rd_sel;
    logic [NUIOIN-1:0] w_load;
    logic [NUIOIN-1:0] w_under_set;

    // Isolate the lowest set strobe bit; extra bits of an illegal
    // multi-hot strobe are ignored entirely.
    assign w_rd_sel    = req_in & (~req_in + NUIOIN'(1));
    assign w_load      = src_valid & ~r_full;
    assign w_under_set = w_rd_sel & ~r_full;

    always_comb begin
        proc_rdata = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (w_rd_sel[k]) begin
                proc_rdata = r_slot_data[k];
            end
        end
    end

    // A load can only happen into an empty slot, so "load" and "read of a
    // full slot" never coincide; a read of an empty slot that is loaded in
    // the same cycle leaves the slot full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full <= '0;
            for (int k = 0; k < NUIOIN; k++) begin
                r_slot_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (w_load[k]) begin
                    r_slot_data[k] <= src_data[k*DW +: DW];
                    r_full[k]      <= 1'b1;
                end else if (w_rd_sel[k]) begin
                    r_full[k]      <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output side and sink arbitration
    // ------------------------------------------------------------------
    logic              w_free;
    logic [NUIOOU-1:0] w_arb_gnt;
    logic [c_OIW-1:0]  w_arb_idx;
    logic              w_arb_any;
    logic [NUIOOU-1:0] w_grant;
    logic [NUIOOU-1:0] w_over_set;
    logic [c_OIW-1:0]  w_ptr_next;

    assign w_free = ~r_snk_valid | snk_ready;

    rr_arbiter #(
        .N  (NUIOOU),
        .IW (c_OIW)
    ) u_arb (
        .req     (r_pend),
        .ptr     (r_ptr),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx),
        .gnt_any (w_arb_any)
    );

    assign w_grant    = w_free ? w_arb_gnt : '0;
    // Writing a port that is being granted this cycle is not a loss: the old
    // word leaves through the sink and the new one takes its place.
    assign w_over_set = out_en & r_pend & ~w_grant;
    assign w_ptr_next = (w_arb_idx == c_OIW'(NUIOOU-1)) ? '0
                                                        : w_arb_idx + c_OIW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend <= '0;
            for (int j = 0; j < NUIOOU; j++) begin
                r_odata[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUIOOU; j++) begin
                if (out_en[j]) begin
                    r_odata[j] <= proc_wdata;
                    r_pend[j]  <= 1'b1;
                end else if (w_grant[j]) begin
                    r_pend[j]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_snk_data  <= '0;
            r_snk_port  <= '0;
            r_snk_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_free) begin
            if (w_arb_any) begin
                r_snk_data  <= r_odata[w_arb_idx];
                r_snk_port  <= w_arb_idx;
                r_snk_valid <= 1'b1;
                r_ptr       <= w_ptr_next;
            end else begin
                r_snk_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set event in the clearing cycle survives the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_underrun <= '0;
            r_overrun  <= '0;
        end else begin
            r_underrun <= (clr_flags ? '0 : r_underrun) | w_under_set;
            r_overrun  <= (clr_flags ? '0 : r_overrun)  | w_over_set;
        end
    end

    assign src_ready = ~r_full;
    assign snk_data  = r_snk_data;
    assign snk_port  = r_snk_port;
    assign snk_valid = r_snk_valid;
    assign underrun  = r_underrun;
    assign overrun   = r_overrun;

endmodule : io_port_ctrl
`default_nettype wire

// File: tb/tb_io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_ctrl
// Description : Self-checking bench for io_port_ctrl. Directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_ctrl;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int W  = 33;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI-1:0]     req_in;
    logic [W-1:0]      proc_rdata;
    logic [NO-1:0]     out_en;
    logic [W-1:0]      proc_wdata;
    logic [NI*W-1:0]   src_data;
    logic [NI-1:0]     src_valid;
    logic [NI-1:0]     src_ready;
    logic [W-1:0]      snk_data;
    logic [1:0]        snk_port;
    logic              snk_valid;
    logic              snk_ready;
    logic [NI-1:0]     underrun;
    logic [NO-1:0]     overrun;
    logic              clr_flags;

    io_port_ctrl #(.NUIOIN(NI), .NUIOOU(NO), .DW(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .proc_rdata (proc_rdata),
        .out_en     (out_en),
        .proc_wdata (proc_wdata),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .snk_data   (snk_data),
        .snk_port   (snk_port),
        .snk_valid  (snk_valid),
        .snk_ready  (snk_ready),
        .underrun   (underrun),
        .overrun    (overrun),
        .clr_flags  (clr_flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    logic [W-1:0]  m_slot  [NI];
    logic [NI-1:0] m_full, m_under;
    logic [W-1:0]  m_odata [NO];
    logic [NO-1:0] m_pend, m_over;
    logic          m_sv;
    logic [W-1:0]  m_sd;
    int            m_sp, m_ptr;

    function automatic int lowest(input logic [NI-1:0] v);
        for (int i = 0; i < NI; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [W-1:0] exp_rdata();
        int k;
        k = lowest(req_in);
        if (k < 0) return '0;
        return m_slot[k];
    endfunction

    // Advance the model by one clock using the inputs currently driven,
    // then advance the DUT and settle just after the edge.
    task automatic tick();
        logic [W-1:0]  n_slot  [NI];
        logic [W-1:0]  n_odata [NO];
        logic [NI-1:0] n_full, n_under;
        logic [NO-1:0] n_pend, n_over;
        logic          n_sv;
        logic [W-1:0]  n_sd;
        int            n_sp, n_ptr, k, g;
        n_slot = m_slot;  n_odata = m_odata;
        n_full = m_full;  n_under = m_under;
        n_pend = m_pend;  n_over  = m_over;
        n_sv = m_sv; n_sd = m_sd; n_sp = m_sp; n_ptr = m_ptr;
        if (rst === 1'b0) begin
            for (int p = 0; p < NI; p++) n_slot[p] = '0;
            for (int p = 0; p < NO; p++) n_odata[p] = '0;
            n_full = '0; n_under = '0; n_pend = '0; n_over = '0;
            n_sv = 1'b0; n_sd = '0; n_sp = 0; n_ptr = 0;
        end else begin
            k = lowest(req_in);
            n_under = clr_flags ? '0 : m_under;
            if (k >= 0 && !m_full[k]) n_under[k] = 1'b1;
            for (int p = 0; p < NI; p++) begin
                if (src_valid[p] && !m_full[p]) begin
                    n_slot[p] = src_data[p*W +: W];
                    n_full[p] = 1'b1;
                end else if (p == k) begin
                    n_full[p] = 1'b0;
                end
            end
            g = -1;
            if (!m_sv || snk_ready) begin
                for (int i = 0; i < NO; i++)
                    if (g < 0 && m_pend[(m_ptr + i) % NO]) g = (m_ptr + i) % NO;
                if (g >= 0) begin
                    n_sv = 1'b1; n_sd = m_odata[g]; n_sp = g;
                    n_ptr = (g + 1) % NO; n_pend[g] = 1'b0;
                end else begin
                    n_sv = 1'b0;
                end
            end
            n_over = clr_flags ? '0 : m_over;
            for (int j = 0; j < NO; j++) begin
                if (out_en[j]) begin
                    if (m_pend[j] && g != j) n_over[j] = 1'b1;
                    n_odata[j] = proc_wdata;
                    n_pend[j]  = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_slot = n_slot;  m_odata = n_odata;
        m_full = n_full;  m_under = n_under;
        m_pend = n_pend;  m_over  = n_over;
        m_sv = n_sv; m_sd = n_sd; m_sp = n_sp; m_ptr = n_ptr;
    endtask

    task automatic idle_inputs();
        req_in = '0; out_en = '0; proc_wdata = '0; src_data = '0;
        src_valid = '0; snk_ready = 1'b1; clr_flags = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        tick(); tick();
        n_checks++; if (snk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_snk_valid: got %b expected 0", snk_valid); end
        n_checks++; if (snk_data !== '0) begin n_fail++; $display("FAIL reset_snk_data: got %h expected 0", snk_data); end
        n_checks++; if (snk_port !== 2'd0) begin n_fail++; $display("FAIL reset_snk_port: got %0d expected 0", snk_port); end
        n_checks++; if (src_ready !== 4'hF) begin n_fail++; $display("FAIL reset_src_ready: got %h expected F", src_ready); end
        n_checks++; if (underrun !== 4'h0 || overrun !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %h/%h expected 0/0", underrun, overrun); end
        // Traffic, then a reset edge in the middle of it.
        rst = 1'b1;
        snk_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            out_en = 4'b0001 << (c % 4);
            proc_wdata = W'({$urandom(), $urandom()});
            src_valid = 4'hF;
            for (int p = 0; p < NI; p++) src_data[p*W +: W] = W'({$urandom(), $urandom()});
            req_in = 4'b0001 << ((c + 1) % 4);
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle_inputs();
        snk_ready = 1'b0;
        n_checks++; if (snk_valid !== 1'b0 || snk_data !== '0 || snk_port !== 2'd0) begin n_fail++; $display("FAIL reset_mid_sink: got %b/%h/%0d expected 0/0/0", snk_valid, snk_data, snk_port); end
        n_checks++; if (src_ready !== 4'hF || underrun !== 4'h0 || overrun !== 4'h0) begin n_fail++; $display("FAIL reset_mid_state: got %h/%h/%h expected F/0/0", src_ready, underrun, overrun); end
        req_in = 4'b1000;
        #1;
        n_checks++; if (proc_rdata !== '0) begin n_fail++; $display("FAIL reset_slot_cleared: got %h expected 0", proc_rdata); end
        req_in = '0;
        tick();
        // No pending word may have survived reset.
        n_checks++; if (snk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_pending: got %b expected 0", snk_valid); end
        snk_ready = 1'b1;
    endtask

    task automatic test_input();
        src_data[2*W +: W] = 33'h0_1234;
        src_valid = 4'b0100;
        tick();
        src_valid = '0;
        n_checks++; if (src_ready !== 4'b1011) begin n_fail++; $display("FAIL input_full: got %b expected 1011", src_ready); end
        req_in = 4'b0100;
        #1;
        n_checks++; if (proc_rdata !== 33'h0_1234) begin n_fail++; $display("FAIL input_rdata: got %h expected 000001234", proc_rdata); end
        tick();
        req_in = '0;
        n_checks++; if (src_ready !== 4'hF) begin n_fail++; $display("FAIL input_ready_back: got %b expected 1111", src_ready); end
        n_checks++; if (underrun !== 4'h0) begin n_fail++; $display("FAIL input_no_underrun: got %b expected 0000", underrun); end
    endtask

    task automatic test_underrun();
        src_data[0 +: W] = 33'h1_0000_ABCD;
        src_valid = 4'b0001;
        tick();
        src_valid = '0;
        req_in = 4'b0001;
        #1;
        n_checks++; if (proc_rdata !== 33'h1_0000_ABCD) begin n_fail++; $display("FAIL under_first_read: got %h expected 10000abcd", proc_rdata); end
        tick();
        #1;
        n_checks++; if (proc_rdata !== 33'h1_0000_ABCD) begin n_fail++; $display("FAIL under_stale_read: got %h expected 10000abcd", proc_rdata); end
        tick();
        req_in = '0;
        n_checks++; if (underrun !== 4'b0001) begin n_fail++; $display("FAIL under_set: got %b expected 0001", underrun); end
        repeat (3) tick();
        n_checks++; if (underrun !== 4'b0001) begin n_fail++; $display("FAIL under_sticky: got %b expected 0001", underrun); end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        n_checks++; if (underrun !== 4'b0000) begin n_fail++; $display("FAIL under_clear: got %b expected 0000", underrun); end
        // Set event coinciding with clear: set wins.
        req_in = 4'b0001; clr_flags = 1'b1;
        tick();
        req_in = '0; clr_flags = 1'b0;
        n_checks++; if (underrun !== 4'b0001) begin n_fail++; $display("FAIL under_set_wins: got %b expected 0001", underrun); end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        // Empty slot loaded and read in the same cycle.
        src_data[1*W +: W] = 33'h0_5A5A_5A5A;
        src_valid = 4'b0010;
        req_in = 4'b0010;
        #1;
        n_checks++; if (proc_rdata !== '0) begin n_fail++; $display("FAIL under_load_read_old: got %h expected 0", proc_rdata); end
        tick();
        src_valid = '0; req_in = '0;
        n_checks++; if (underrun !== 4'b0010 || src_ready !== 4'b1101) begin n_fail++; $display("FAIL under_load_read: got %b/%b expected 0010/1101", underrun, src_ready); end
        req_in = 4'b0010;
        #1;
        n_checks++; if (proc_rdata !== 33'h0_5A5A_5A5A) begin n_fail++; $display("FAIL under_load_kept: got %h expected 05a5a5a5a", proc_rdata); end
        tick();
        req_in = '0;
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    endtask

    task automatic test_arbitration();
        int            exp_port [3];
        logic [W-1:0]  exp_word [3];
        snk_ready = 1'b0;
        out_en = 4'b1000; proc_wdata = 33'h0_0000_00A3;
        tick();
        out_en = '0;
        tick();
        n_checks++; if (snk_valid !== 1'b1 || snk_port !== 2'd3 || snk_data !== 33'h0_0000_00A3) begin n_fail++; $display("FAIL arb_first: got %b/%0d/%h expected 1/3/0000000a3", snk_valid, snk_port, snk_data); end
        out_en = 4'b1000; proc_wdata = 33'h0_0000_00B3; tick();
        out_en = 4'b0010; proc_wdata = 33'h0_0000_00B1; tick();
        out_en = 4'b0001; proc_wdata = 33'h0_0000_00B0; tick();
        out_en = '0;
        n_checks++; if (snk_port !== 2'd3 || snk_data !== 33'h0_0000_00A3) begin n_fail++; $display("FAIL arb_hold: got %0d/%h expected 3/0000000a3", snk_port, snk_data); end
        exp_port = '{0, 1, 3};
        exp_word = '{33'h0_0000_00B0, 33'h0_0000_00B1, 33'h0_0000_00B3};
        snk_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (snk_valid !== 1'b1 || snk_port !== 2'(exp_port[i]) || snk_data !== exp_word[i]) begin n_fail++; $display("FAIL arb_order[%0d]: got %b/%0d/%h expected 1/%0d/%h", i, snk_valid, snk_port, snk_data, exp_port[i], exp_word[i]); end
        end
        tick();
        n_checks++; if (snk_valid !== 1'b0) begin n_fail++; $display("FAIL arb_drained: got %b expected 0", snk_valid); end
        // Refill: port 0 is granted, then ports 3 and 0 both pend; 3 goes first.
        snk_ready = 1'b0;
        out_en = 4'b0001; proc_wdata = 33'h0_0000_00C0; tick();
        out_en = 4'b1000; proc_wdata = 33'h0_0000_00C3; tick();
        n_checks++; if (snk_port !== 2'd0 || snk_data !== 33'h0_0000_00C0) begin n_fail++; $display("FAIL arb_refill_grant: got %0d/%h expected 0/0000000c0", snk_port, snk_data); end
        out_en = 4'b0001; proc_wdata = 33'h1_0000_00C0; tick();
        out_en = '0;
        n_checks++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL arb_refill_no_over: got %b expected 0000", overrun); end
        snk_ready = 1'b1;
        tick();
        n_checks++; if (snk_port !== 2'd3 || snk_data !== 33'h0_0000_00C3) begin n_fail++; $display("FAIL arb_fair_3: got %0d/%h expected 3/0000000c3", snk_port, snk_data); end
        tick();
        n_checks++; if (snk_port !== 2'd0 || snk_data !== 33'h1_0000_00C0) begin n_fail++; $display("FAIL arb_fair_0: got %0d/%h expected 0/1000000c0", snk_port, snk_data); end
        tick();
        n_checks++; if (snk_valid !== 1'b0) begin n_fail++; $display("FAIL arb_fair_drained: got %b expected 0", snk_valid); end
    endtask

    task automatic test_backpressure();
        snk_ready = 1'b0;
        out_en = 4'b0100; proc_wdata = 33'h0_0000_0E01; tick();
        out_en = '0; tick();
        for (int i = 0; i < 5; i++) begin
            out_en = (i == 1 || i == 3) ? 4'b0100 : 4'b0000;
            proc_wdata = (i == 1) ? 33'h0_0000_0E02 : 33'h0_0000_0E03;
            tick();
            out_en = '0;
            n_checks++; if (snk_valid !== 1'b1 || snk_port !== 2'd2 || snk_data !== 33'h0_0000_0E01) begin n_fail++; $display("FAIL bp_stable[%0d]: got %b/%0d/%h expected 1/2/000000e01", i, snk_valid, snk_port, snk_data); end
        end
        n_checks++; if (overrun !== 4'b0100) begin n_fail++; $display("FAIL bp_overrun: got %b expected 0100", overrun); end
        snk_ready = 1'b1;
        tick();
        n_checks++; if (snk_port !== 2'd2 || snk_data !== 33'h0_0000_0E03) begin n_fail++; $display("FAIL bp_latest_word: got %0d/%h expected 2/000000e03", snk_port, snk_data); end
        tick();
        n_checks++; if (snk_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", snk_valid); end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        n_checks++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL bp_clear: got %b expected 0000", overrun); end
    endtask

    task automatic test_collision();
        snk_ready = 1'b1;
        out_en = 4'b0010; proc_wdata = 33'h0_0000_0F01; tick();
        out_en = 4'b0010; proc_wdata = 33'h0_0000_0F02; tick();
        out_en = '0;
        n_checks++; if (snk_port !== 2'd1 || snk_data !== 33'h0_0000_0F01 || overrun !== 4'b0000) begin n_fail++; $display("FAIL coll_old_word: got %0d/%h/%b expected 1/000000f01/0000", snk_port, snk_data, overrun); end
        tick();
        n_checks++; if (snk_valid !== 1'b1 || snk_port !== 2'd1 || snk_data !== 33'h0_0000_0F02 || overrun !== 4'b0000) begin n_fail++; $display("FAIL coll_new_word: got %b/%0d/%h/%b expected 1/1/000000f02/0000", snk_valid, snk_port, snk_data, overrun); end
        tick();
        n_checks++; if (snk_valid !== 1'b0) begin n_fail++; $display("FAIL coll_drained: got %b expected 0", snk_valid); end
    endtask

    task automatic test_back_to_back();
        int exp_port [3];
        snk_ready = 1'b0;
        for (int j = 0; j < NO; j++) begin
            out_en = 4'b0001 << j;
            proc_wdata = 33'h1_0000_0000 + W'(j);
            tick();
        end
        out_en = '0;
        n_checks++; if (snk_valid !== 1'b1 || snk_port !== 2'd0 || snk_data !== 33'h1_0000_0000) begin n_fail++; $display("FAIL b2b_first: got %b/%0d/%h expected 1/0/100000000", snk_valid, snk_port, snk_data); end
        exp_port = '{1, 2, 3};
        snk_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (snk_valid !== 1'b1 || snk_port !== 2'(exp_port[i]) || snk_data !== 33'h1_0000_0000 + W'(exp_port[i])) begin n_fail++; $display("FAIL b2b[%0d]: got %b/%0d/%h expected 1/%0d", i, snk_valid, snk_port, snk_data, exp_port[i]); end
        end
        tick();
        n_checks++; if (snk_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", snk_valid); end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            r = $urandom_range(0, 9);
            req_in = (r < 4) ? (4'b0001 << r) : (r == 4) ? 4'($urandom()) : 4'b0000;
            r = $urandom_range(0, 7);
            out_en = (r < 4) ? (4'b0001 << r) : 4'b0000;
            proc_wdata = W'({$urandom(), $urandom()});
            src_valid = 4'($urandom());
            for (int p = 0; p < NI; p++) src_data[p*W +: W] = W'({$urandom(), $urandom()});
            snk_ready = ($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++; if (proc_rdata !== exp_rdata()) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h expected %h", c, proc_rdata, exp_rdata()); end
            tick();
            n_checks++; if (snk_valid !== m_sv) begin n_fail++; $display("FAIL rnd_snk_valid@%0d: got %b expected %b", c, snk_valid, m_sv); end
            n_checks++; if (snk_port !== 2'(m_sp)) begin n_fail++; $display("FAIL rnd_snk_port@%0d: got %0d expected %0d", c, snk_port, m_sp); end
            n_checks++; if (snk_data !== m_sd) begin n_fail++; $display("FAIL rnd_snk_data@%0d: got %h expected %h", c, snk_data, m_sd); end
            n_checks++; if (src_ready !== ~m_full) begin n_fail++; $display("FAIL rnd_src_ready@%0d: got %b expected %b", c, src_ready, ~m_full); end
            n_checks++; if (underrun !== m_under) begin n_fail++; $display("FAIL rnd_underrun@%0d: got %b expected %b", c, underrun, m_under); end
            n_checks++; if (overrun !== m_over) begin n_fail++; $display("FAIL rnd_overrun@%0d: got %b expected %b", c, overrun, m_over); end
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_input();
        test_underrun();
        test_arbitration();
        test_backpressure();
        test_collision();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_io_port_ctrl
`default_nettype wire
